i_memory_loader: RTL and testbench
==================================

// Module: i_memory_loader
// PURPOSE
// Parametrised instruction memory for the 5-stage pipeline: one synchronous write port
// for loading a program word-by-word over a valid/ready stream, and one pipelined read port
// for the IF stage. After each load it zero-fills all unloaded words, then presents a fetch
// port with configurable read latency and stall hold. It replaces file-based init with a
// load handshake so a bench or boot loader can reprogram the memory without a reset.
// PARAMETERS
// ISIZE      16  instruction width in bits
// MEM_SPACE  8   address width; DEPTH = 2**MEM_SPACE words
// READ_LAT   1   fetch latency in cycles, legal values 1 or 2
// PORTS
// clk         in   1            rising-edge clock
// rst_n       in   1            asynchronous active-low reset
// load_start  in   1            1-cycle pulse: begin a new program load
// load_valid  in   1            load_data valid
// load_data   in   ISIZE        instruction word to write
// load_last   in   1            qualifies the final word of the program
// load_ready  out  1            a word is accepted when load_valid & load_ready
// busy        out  1            state is LOAD or CLEAR
// ready       out  1            state is READY; fetches are served
// load_count  out  MEM_SPACE+1  number of words accepted in the most recent load
// load_err    out  1            sticky: DEPTH words taken without load_last
// fetch_en    in   1            issue a read of address this cycle
// stall       in   1            freeze the read pipeline
// address     in   MEM_SPACE    fetch word address
// data_out    out  ISIZE        fetched instruction
// data_valid  out  1            data_out holds a word from an issued fetch
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE; data_out=0, data_valid=0, load_ready=0, busy=0,
//   ready=0, load_count=0, load_err=0; pipeline flushed. Array contents are not reset.
// - FSM IDLE->LOAD on load_start. Write pointer wp=0. load_count=0. load_err=0.
// - LOAD: load_ready=1. On accept, mem[wp]<=load_data, wp++, load_count++.
//   Accept with load_last -> CLEAR (or READY if wp+1==DEPTH).
//   Accept at wp==DEPTH-1 without load_last -> load_err=1, go to READY.
// - CLEAR: load_ready=0; writes mem[wp]<=0 one word per cycle, wp++. Leaves after wp=DEPTH-1
//   is written -> READY. Loaded words are never overwritten; clear starts at load_count.
// - READY: ready=1. load_start -> LOAD, flushes the read pipeline (data_valid=0 next cycle).
//   load_start in LOAD or CLEAR is ignored. load_start with fetch_en in READY: load wins.
// - Read pipe. Issue = fetch_en & ready & ~stall. READ_LAT=1: data_out<=mem[address] at
//   the next edge. READ_LAT=2: an extra output register is added; data is valid 2 edges later.
//   Throughput is 1 word/cycle. data_valid follows the issue through the same stages.
//   A non-issue inserts a bubble (data_valid=0).
// - stall=1: all read stages hold; data_out and data_valid are unchanged; address is ignored.
// - fetch_en outside READY: no read is issued; bubble.
// - load_count saturates at DEPTH (MEM_SPACE+1 bits, so no wrap). wp never wraps past DEPTH-1.
// - rst_n mid-LOAD or mid-CLEAR: abort to IDLE; memory is partial; ready=0 until a new load.
// TESTING
// 1 Load 0x1111,0x2222,0x3333 (last on 3rd); then fetch 0..4 -> 1111,2222,3333,0000,0000
//   with load_count=3, CLEAR lasting DEPTH-3 cycles, and ready rising after it.
// 2 Load DEPTH words with last on the final word -> no CLEAR, load_err=0.
//   Repeat without last -> load_err=1, ready=1, and extra load_valid is ignored.
// 3 Fetch 0,1,2 back-to-back; stall 2 cycles after issuing 1 -> data_out holds 2222 during
//   the stall, and 3333 follows. No word is dropped or duplicated.
// 4 READ_LAT=2 build: address=k at cycle t -> mem[k] at t+2; streaming 0..7 gives 8
//   consecutive valid words.
// 5 rst_n low after 2 words of a load -> all outputs 0 immediately (async). A new 4-word load
//   then reads back correctly.
// 6 load_start together with fetch_en in READY -> data_valid=0 next cycle, load_ready=1,
//   busy=1, and the fetch is discarded.

Source files
------------

// File: rtl/i_memory_loader.sv
// rtl/i_memory_loader.sv - program-loadable instruction memory with pipelined fetch port
// Loads words over a valid/ready stream, zero-fills the tail, then serves fetches.
module i_memory_loader #(
  parameter int ISIZE     = 16,
  parameter int MEM_SPACE = 8,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [ISIZE-1:0]     load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 busy,
  output logic                 ready,
  output logic [MEM_SPACE:0]   load_count,
  output logic                 load_err,
  input  logic                 fetch_en,
  input  logic                 stall,
  input  logic [MEM_SPACE-1:0] address,
  output logic [ISIZE-1:0]     data_out,
  output logic                 data_valid
);
  localparam int DEPTH = 2**MEM_SPACE;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;
  localparam logic [MEM_SPACE:0]   FULL_CNT = {1'b1, {MEM_SPACE{1'b0}}};
  localparam logic [MEM_SPACE-1:0] LAST_WP  = {MEM_SPACE{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [MEM_SPACE-1:0] wp_q, wp_d;
  logic [MEM_SPACE:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 wr_en;
  logic [ISIZE-1:0]     wr_data;
  logic [ISIZE-1:0]     mem [DEPTH];
  logic                 wp_at_end, flush, issue;
  logic [ISIZE-1:0]     rd_data_q;
  logic                 rd_valid_q;

  assign wp_at_end = (wp_q == LAST_WP);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_data = load_data;
    case (state_q)
      S_IDLE, S_READY: begin
        if (load_start) begin
          state_d = S_LOAD;
          wp_d    = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          if (count_q != FULL_CNT) count_d = count_q + 1'b1;
          // The final slot ends the load either way; without last it is an overflow.
          if (wp_at_end) begin
            state_d = S_READY;
            err_d   = ~load_last;
          end else begin
            wp_d = wp_q + 1'b1;
            if (load_last) state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (wp_at_end) state_d = S_READY;
        else           wp_d    = wp_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= wr_data;
  end

  // A new load from READY discards anything in flight, even under stall.
  assign flush = load_start & (state_q == S_READY);
  assign issue = fetch_en & (state_q == S_READY) & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush) begin
      rd_valid_q <= 1'b0;
    end else if (!stall) begin
      rd_valid_q <= issue;
      if (issue) rd_data_q <= mem[address];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [ISIZE-1:0] out_data_q;
      logic             out_valid_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (!stall) begin
          out_data_q  <= rd_data_q;
          out_valid_q <= rd_valid_q;
        end
      end
      assign data_out   = out_data_q;
      assign data_valid = out_valid_q;
    end else begin : g_lat1
      assign data_out   = rd_data_q;
      assign data_valid = rd_valid_q;
    end
  endgenerate

  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) | (state_q == S_CLEAR);
  assign ready      = (state_q == S_READY);
  assign load_count = count_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_i_memory_loader.sv
// tb/tb_i_memory_loader.sv - bench for i_memory_loader, latency 1 and 2 instances side by side
module tb_i_memory_loader;
  localparam int ISIZE = 16;
  localparam int MS    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, fetch_en = 1'b0, stall = 1'b0;
  logic [ISIZE-1:0] load_data = '0;
  logic [MS-1:0]    address = '0;
  logic load_ready, busy, ready, load_err, dv1;
  logic load_ready2, busy2, ready2, load_err2, dv2;
  logic [MS:0] load_count, load_count2;
  logic [ISIZE-1:0] do1, do2;

  i_memory_loader #(.ISIZE(ISIZE), .MEM_SPACE(MS), .READ_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready), .busy(busy),
    .ready(ready), .load_count(load_count), .load_err(load_err), .fetch_en(fetch_en),
    .stall(stall), .address(address), .data_out(do1), .data_valid(dv1));

  i_memory_loader #(.ISIZE(ISIZE), .MEM_SPACE(MS), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready2), .busy(busy2),
    .ready(ready2), .load_count(load_count2), .load_err(load_err2), .fetch_en(fetch_en),
    .stall(stall), .address(address), .data_out(do2), .data_valid(dv2));

  always #5 clk = ~clk;

  typedef struct { bit v; logic [ISIZE-1:0] d; } pipe_t;
  typedef struct { int addr; logic [ISIZE-1:0] exp; } vec_t;

  // Reference: phase 0 idle, 1 load, 2 clear, 3 ready; hist holds the last two
  // unstalled pipeline entries, newest at the back.
  pipe_t hist[$];
  logic [ISIZE-1:0] m_mem [DEPTH];
  logic [ISIZE-1:0] prog  [DEPTH];
  int m_st, m_cnt, m_clr;
  bit m_err, m_acc;
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_clr = 0; m_err = 0; m_acc = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    pipe_t e;
    m_acc = 0;
    if (load_start && m_st == 3) begin
      e.v = 0; e.d = '0;
      hist.push_back(e); hist.push_back(e);
    end else if (!stall) begin
      e.v = fetch_en && (m_st == 3);
      e.d = m_mem[address];
      hist.push_back(e);
    end
    while (hist.size() > 2) void'(hist.pop_front());
    case (m_st)
      0, 3: if (load_start) begin m_st = 1; m_cnt = 0; m_err = 0; end
      1: if (load_valid) begin
        m_acc = 1;
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (load_last || m_cnt == DEPTH) begin
          m_err = !load_last;
          for (int k = m_cnt; k < DEPTH; k++) m_mem[k] = '0;
          m_clr = DEPTH - m_cnt;
          m_st  = (m_clr == 0) ? 3 : 2;
        end
      end
      2: begin m_clr--; if (m_clr == 0) m_st = 3; end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit ev1, ev2;
    ev1 = 0; ev2 = 0;
    if (hist.size() >= 1) ev1 = hist[$].v;
    if (hist.size() >= 2) ev2 = hist[$-1].v;
    chk("load_ready", load_ready, m_st == 1);
    chk("busy", busy, m_st == 1 || m_st == 2);
    chk("ready", ready, m_st == 3);
    chk("load_count", load_count, m_cnt);
    chk("load_err", load_err, m_err);
    chk("ready_lat2", ready2, m_st == 3);
    chk("busy_lat2", busy2, m_st == 1 || m_st == 2);
    chk("load_ready_lat2", load_ready2, m_st == 1);
    chk("load_count_lat2", load_count2, m_cnt);
    chk("load_err_lat2", load_err2, m_err);
    chk("data_valid_lat1", dv1, ev1);
    if (ev1) chk("data_out_lat1", do1, hist[$].d);
    chk("data_valid_lat2", dv2, ev2);
    if (ev2) chk("data_out_lat2", do2, hist[$-1].d);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_load(int n, bit with_last, bit gaps, bit pulse);
    int i, guard;
    i = 0; guard = 0;
    if (pulse) begin load_start = 1; step(); load_start = 0; end
    while (i < n && guard < 8 * DEPTH) begin
      load_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      load_data  = prog[i];
      load_last  = with_last && (i == n - 1);
      step();
      guard++;
      if (m_acc) i++;
    end
    load_valid = 0; load_last = 0;
    if (i < n) chk("load_words_timeout", i, n);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 4 * DEPTH) begin step(); cycles++; end
    chk("ready_reached", ready, 1);
  endtask

  task automatic fetch(int a);
    fetch_en = 1; address = MS'(a); step();
  endtask

  initial begin
    vec_t t1 [5];
    int cyc, vcnt;
    t1[0] = '{0, 16'h1111}; t1[1] = '{1, 16'h2222}; t1[2] = '{2, 16'h3333};
    t1[3] = '{3, 16'h0000}; t1[4] = '{4, 16'h0000};
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_data_out", do1, 0);
    @(negedge clk); rst_n = 1;

    // 1: short load, tail clear, table-driven readback
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
    do_load(3, 1, 0, 1);
    wait_ready(cyc);
    chk("t1_clear_cycles", cyc, DEPTH - 3);
    chk("t1_load_count", load_count, 3);
    for (int i = 0; i < 5; i++) begin
      fetch(t1[i].addr);
      chk("t1_valid", dv1, 1);
      chk("t1_fetch", do1, t1[i].exp);
    end
    fetch_en = 0; step();

    // 2: full load with and without last
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
    do_load(DEPTH, 1, 1, 1);
    chk("t2_ready_no_clear", ready, 1);
    chk("t2_err_clear", load_err, 0);
    chk("t2_count_full", load_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
    do_load(DEPTH, 0, 0, 1);
    chk("t2_err_set", load_err, 1);
    chk("t2_ready", ready, 1);
    load_valid = 1; load_data = 16'hdead;
    repeat (3) step();
    load_valid = 0;
    chk("t2_count_held", load_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) fetch(i);
    fetch_en = 0; step(); step();

    // 3: stall holds the output stage
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
    do_load(3, 1, 0, 1);
    wait_ready(cyc);
    fetch(0); chk("t3_w0", do1, 16'h1111);
    fetch(1); chk("t3_w1", do1, 16'h2222);
    stall = 1; address = 2;
    step(); chk("t3_hold1", do1, 16'h2222); chk("t3_hold1_v", dv1, 1);
    step(); chk("t3_hold2", do1, 16'h2222);
    stall = 0;
    fetch(2); chk("t3_w2", do1, 16'h3333);
    fetch_en = 0; step(); chk("t3_bubble", dv1, 0);
    step();

    // 4: latency-2 streaming
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
    do_load(DEPTH, 1, 0, 1);
    vcnt = 0;
    for (int a = 0; a < 8; a++) begin
      fetch(a);
      if (dv2) vcnt++;
      if (a >= 1) chk("t4_lat2_data", do2, prog[a-1]);
    end
    fetch_en = 0;
    step(); if (dv2) vcnt++;
    chk("t4_last_word", do2, prog[7]);
    step(); if (dv2) vcnt++;
    chk("t4_valid_count", vcnt, 8);

    // 5: asynchronous reset mid-load, then reload
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = prog[0]; step();
    load_data = prog[1]; step();
    load_valid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("t5_load_count", load_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", ready, 0);
    chk("t5_load_ready", load_ready, 0);
    chk("t5_dout1", do1, 0);
    chk("t5_dout2", do2, 0);
    chk("t5_dv2", dv2, 0);
    @(negedge clk); rst_n = 1;
    step();
    do_load(4, 1, 1, 1);
    wait_ready(cyc);
    for (int i = 0; i < 4; i++) begin
      fetch(i);
      chk("t5_readback", do1, prog[i]);
    end

    // 6: load_start beats a simultaneous fetch
    load_start = 1; fetch_en = 1; address = 1;
    step();
    load_start = 0; fetch_en = 0;
    chk("t6_dv1", dv1, 0);
    chk("t6_dv2", dv2, 0);
    chk("t6_load_ready", load_ready, 1);
    chk("t6_busy", busy, 1);
    do_load(5, 1, 0, 0);
    wait_ready(cyc);

    // randomized traffic against the reference
    for (int c = 0; c < 400; c++) begin
      load_start = ($urandom_range(39) == 0);
      load_valid = $urandom_range(1);
      load_last  = ($urandom_range(5) == 0);
      load_data  = 16'($urandom);
      fetch_en   = ($urandom_range(3) != 0);
      stall      = ($urandom_range(3) == 0);
      address    = MS'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
